// File: rtl/guess_seq_ctrl.sv
// Round sequencer for the number-guess game: debounced enter, one compare per
// press over a start/done handshake, result flags, attempt count, win/lose stop.
//
// state    | meaning
// IDLE     | waiting for a debounced press
// ISSUE    | one-cycle compare request with the latched guess
// WAIT_CMP | waiting for comparator done, bounded by CMP_TIMEOUT
// UPDATE   | load flags, strobe LEDs, consume one attempt
// WON      | terminal: last result was equal
// LOST     | terminal: attempts exhausted without a match
module guess_seq_ctrl #(
  parameter int MAX_ATTEMPTS    = 7,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CMP_TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enter,
  input  logic [7:0] i_guess,
  output logic       o_cmp_start,
  output logic [7:0] o_cmp_guess,
  input  logic       i_cmp_done,
  input  logic [1:0] i_cmp_result,
  output logic       o_under,
  output logic       o_over,
  output logic       o_equal,
  output logic       o_update_leds,
  output logic [3:0] o_remaining_attempts,
  output logic       o_cmp_err,
  output logic       o_busy,
  output logic       o_game_over
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(CMP_TIMEOUT + 1);
  localparam logic [1:0] RES_UNDER = 2'b00;
  localparam logic [1:0] RES_OVER  = 2'b01;
  localparam logic [1:0] RES_EQUAL = 2'b10;
  localparam logic [1:0] RES_BAD   = 2'b11;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_CMP, UPDATE, WON, LOST
  } state_t;

  state_t          state, state_nxt;
  logic            enter_meta, enter_sync, enter_db, enter_db_q;
  logic [DW-1:0]   db_cnt;
  logic [TW-1:0]   cmp_timer;
  logic [1:0]      result_q;
  logic [3:0]      attempts_dec;
  logic            press_evt;
  logic            latch_guess, load_timer, set_err, capture, do_update;

  // Debounce down-counter reloads while the synced level matches the accepted one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enter_meta <= 1'b0;
      enter_sync <= 1'b0;
      enter_db   <= 1'b0;
      enter_db_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      enter_meta <= i_enter;
      enter_sync <= enter_meta;
      enter_db_q <= enter_db;
      if (enter_sync == enter_db) begin
        db_cnt <= DW'(DEBOUNCE_CYCLES - 1);
      end else if (db_cnt == '0) begin
        enter_db <= enter_sync;
      end else begin
        db_cnt <= db_cnt - 1'b1;
      end
    end
  end

  assign press_evt    = enter_db & ~enter_db_q;
  assign attempts_dec = (o_remaining_attempts == 4'd0) ? 4'd0 : o_remaining_attempts - 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    latch_guess = 1'b0;
    load_timer  = 1'b0;
    set_err     = 1'b0;
    capture     = 1'b0;
    do_update   = 1'b0;
    case (state)
      IDLE: begin
        if (press_evt) begin
          latch_guess = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        load_timer = 1'b1;
        state_nxt  = WAIT_CMP;
      end
      WAIT_CMP: begin
        if (i_cmp_done) begin
          if (i_cmp_result == RES_BAD) begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end else begin
            capture   = 1'b1;
            state_nxt = UPDATE;
          end
        end else if (cmp_timer == '0) begin
          set_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      UPDATE: begin
        do_update = 1'b1;
        if (result_q == RES_EQUAL)     state_nxt = WON;
        else if (attempts_dec == 4'd0) state_nxt = LOST;
        else                           state_nxt = IDLE;
      end
      WON:     state_nxt = WON;
      LOST:    state_nxt = LOST;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_cmp_guess          <= 8'd0;
      o_cmp_err            <= 1'b0;
      o_under              <= 1'b0;
      o_over               <= 1'b0;
      o_equal              <= 1'b0;
      o_update_leds        <= 1'b0;
      o_remaining_attempts <= 4'(MAX_ATTEMPTS);
      cmp_timer            <= '0;
      result_q             <= 2'b00;
    end else begin
      o_update_leds <= 1'b0;
      if (latch_guess) begin
        o_cmp_guess <= i_guess;
        o_cmp_err   <= 1'b0;
      end
      if (set_err) o_cmp_err <= 1'b1;
      if (load_timer) cmp_timer <= TW'(CMP_TIMEOUT - 1);
      else if (state == WAIT_CMP && cmp_timer != '0) cmp_timer <= cmp_timer - 1'b1;
      if (capture) result_q <= i_cmp_result;
      if (do_update) begin
        o_under              <= (result_q == RES_UNDER);
        o_over               <= (result_q == RES_OVER);
        o_equal              <= (result_q == RES_EQUAL);
        o_update_leds        <= 1'b1;
        o_remaining_attempts <= attempts_dec;
      end
    end
  end

  assign o_cmp_start = (state == ISSUE);
  assign o_busy      = (state == ISSUE) || (state == WAIT_CMP);
  assign o_game_over = (state == WON) || (state == LOST);

endmodule

// File: tb/tb_guess_seq_ctrl.sv
// Bench for guess_seq_ctrl: directed and randomized rounds checked against a
// round-level game model (attempts, flags, error, game-over).
module tb_guess_seq_ctrl;

  localparam int MAX_ATTEMPTS    = 7;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CMP_TIMEOUT     = 15;
  localparam int NO_DONE         = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_enter;
  logic [7:0] i_guess;
  logic       o_cmp_start;
  logic [7:0] o_cmp_guess;
  logic       i_cmp_done;
  logic [1:0] i_cmp_result;
  logic       o_under, o_over, o_equal, o_update_leds;
  logic [3:0] o_remaining_attempts;
  logic       o_cmp_err, o_busy, o_game_over;

  int n_pass  = 0;
  int n_total = 0;

  // round-level model: flag 0 under, 1 over, 2 equal, 3 none
  int m_att;
  int m_flag;
  bit m_err;
  bit m_game;

  guess_seq_ctrl #(
    .MAX_ATTEMPTS(MAX_ATTEMPTS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CMP_TIMEOUT(CMP_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_enter(i_enter),
    .i_guess(i_guess),
    .o_cmp_start(o_cmp_start),
    .o_cmp_guess(o_cmp_guess),
    .i_cmp_done(i_cmp_done),
    .i_cmp_result(i_cmp_result),
    .o_under(o_under),
    .o_over(o_over),
    .o_equal(o_equal),
    .o_update_leds(o_update_leds),
    .o_remaining_attempts(o_remaining_attempts),
    .o_cmp_err(o_cmp_err),
    .o_busy(o_busy),
    .o_game_over(o_game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".attempts"}, o_remaining_attempts, m_att);
    chk({tag, ".under"}, o_under, m_flag == 0);
    chk({tag, ".over"}, o_over, m_flag == 1);
    chk({tag, ".equal"}, o_equal, m_flag == 2);
    chk({tag, ".err"}, o_cmp_err, m_err);
    chk({tag, ".game_over"}, o_game_over, m_game);
    chk({tag, ".busy"}, o_busy, 1'b0);
  endtask

  task automatic apply_reset();
    i_enter    = 1'b0;
    i_cmp_done = 1'b0;
    reset      = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    m_att  = MAX_ATTEMPTS;
    m_flag = 3;
    m_err  = 1'b0;
    m_game = 1'b0;
  endtask

  // One press of length hold; done is returned d cycles after the start cycle.
  task automatic round(input string tag, input logic [7:0] g, input int hold,
                       input int d, input logic [1:0] res);
    int  starts = 0;
    int  ups = 0;
    int  start_cyc = -1;
    int  up_cyc = -1;
    bit  exp_issue;
    bit  accepted;
    exp_issue = !m_game;
    accepted  = exp_issue && (res != 2'b11) && (d >= 1) && (d <= CMP_TIMEOUT);
    i_guess = g;
    for (int cyc = 0; cyc < 60; cyc++) begin
      tick();
      if (o_cmp_start) begin
        starts++;
        start_cyc = cyc;
      end
      if (o_update_leds) begin
        ups++;
        if (up_cyc < 0) up_cyc = cyc;
      end
      i_enter      = (cyc < hold);
      i_cmp_done   = (start_cyc >= 0) && (cyc - start_cyc == d);
      i_cmp_result = i_cmp_done ? res : 2'($urandom_range(0, 3));
      if (start_cyc >= 0) i_guess = 8'($urandom);
    end
    i_cmp_done = 1'b0;
    if (exp_issue) begin
      m_err = 1'b0;
      if (accepted) begin
        m_att  = m_att - 1;
        m_flag = res;
        if (res == 2'b10 || m_att == 0) m_game = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    chk({tag, ".starts"}, starts, exp_issue);
    chk({tag, ".updates"}, ups, accepted);
    if (accepted) chk({tag, ".update_latency"}, up_cyc - start_cyc, d + 2);
    if (exp_issue) chk({tag, ".guess"}, o_cmp_guess, g);
    check_state(tag);
  endtask

  initial begin
    int starts;
    int ups;
    int nr;
    i_guess      = 8'd0;
    i_cmp_result = 2'b00;
    apply_reset();

    chk("reset.start", o_cmp_start, 1'b0);
    chk("reset.update", o_update_leds, 1'b0);
    chk("reset.guess", o_cmp_guess, 8'd0);
    check_state("reset");

    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      starts += int'(o_cmp_start);
    end
    chk("idle.starts", starts, 0);

    starts = 0;
    for (int i = 0; i < 25; i++) begin
      i_enter = (i < 3);
      tick();
      starts += int'(o_cmp_start);
    end
    chk("glitch.starts", starts, 0);

    // win on the third press
    round("r1", 8'h2A, 20, 2, 2'b00);
    round("r2", 8'h11, 12, 5, 2'b01);
    round("r3", 8'h33, 15, 1, 2'b10);
    round("won_press", 8'h44, 15, 2, 2'b00);

    // lose after seven over results
    apply_reset();
    for (int i = 0; i < 7; i++) round("lose", 8'(i + 1), 10, 3, 2'b01);
    round("lost_press", 8'h99, 10, 3, 2'b10);

    // timeouts, invalid result, boundary done timing
    apply_reset();
    round("timeout", 8'h10, 10, NO_DONE, 2'b00);
    round("invalid", 8'h20, 10, 4, 2'b11);
    round("clear_err", 8'h30, 10, 1, 2'b00);
    round("same_cycle_done", 8'h40, 10, 0, 2'b01);
    round("last_ok_done", 8'h50, 10, CMP_TIMEOUT, 2'b01);
    round("late_done", 8'h60, 10, CMP_TIMEOUT + 1, 2'b01);

    // reset while waiting for the comparator, then a stale done
    apply_reset();
    i_guess = 8'h55;
    i_enter = 1'b1;
    starts  = 0;
    for (int i = 0; i < 40 && starts == 0; i++) begin
      tick();
      starts += int'(o_cmp_start);
    end
    chk("midreset.start_seen", starts, 1);
    tick();
    tick();
    i_enter = 1'b0;
    reset   = 1'b0;
    #2;
    chk("midreset.busy_async", o_busy, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    i_cmp_done   = 1'b1;
    i_cmp_result = 2'b10;
    tick();
    i_cmp_done = 1'b0;
    ups = 0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      ups += int'(o_update_leds);
      starts += int'(o_cmp_start);
      tick();
    end
    m_att = MAX_ATTEMPTS; m_flag = 3; m_err = 1'b0; m_game = 1'b0;
    chk("midreset.updates", ups, 0);
    chk("midreset.starts", starts, 0);
    check_state("midreset");

    // randomized games
    for (int g = 0; g < 3; g++) begin
      apply_reset();
      nr = 0;
      while (!m_game && nr < 25) begin
        round("rand", 8'($urandom), int'($urandom_range(8, 20)),
              int'($urandom_range(0, 18)), 2'($urandom_range(0, 3)));
        nr++;
      end
      round("rand_after", 8'($urandom), 10, 2, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/guess_seq_ctrl.md
Name: guess_seq_ctrl

Overview:
- Round sequencer for the number-guess game datapath.
- Debounces the enter key, latches the switch guess, and issues one compare request per press to an external comparator over a start/done handshake.
- Converts the compare result into under/over/equal flags plus an LED-update strobe, counts remaining attempts, and stops in a terminal win or lose state.
- Sits between the top-level key/switch inputs and the comparator, LED controllers and attempts HEX decoder.

Parameters:
- MAX_ATTEMPTS, 7, attempts per game; legal range 1..15.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before the enter level is accepted (10 ms at 50 MHz).
- CMP_TIMEOUT, 15, cycles to wait for i_cmp_done before abandoning a compare.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i_enter  in  1  raw enter level, active-high, asynchronous to clk.
- i_guess  in  8  switch guess value.
- o_cmp_start  out  1  one-cycle compare request.
- o_cmp_guess  out  8  latched guess presented to the comparator.
- i_cmp_done  in  1  comparator completion strobe.
- i_cmp_result  in  2  compare result: 00 under, 01 over, 10 equal, 11 invalid.
- o_under, o_over, o_equal  out  1 each  result flags; at most one is high.
- o_update_leds  out  1  one-cycle strobe when the flags change.
- o_remaining_attempts  out  4  attempts left.
- o_cmp_err  out  1  sticky compare-error flag.
- o_busy  out  1  high in ISSUE and WAIT_CMP.
- o_game_over  out  1  high in WON and LOST.

Behaviour:
- Reset (asynchronous, reset=0):
  - State goes to IDLE.
  - o_remaining_attempts = MAX_ATTEMPTS.
  - All flags, strobes, o_cmp_err, o_busy and o_game_over = 0.
  - o_cmp_guess = 0; debounce counter and synchronizer cleared.
  - Reset mid-compare abandons the compare; a late i_cmp_done after reset is ignored.
- Enter path:
  - 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synced value.
  - A press event is a one-cycle pulse on the debounced rising edge.
  - Presses are accepted only in IDLE. Presses in any other state are dropped, not queued.
  - A held key yields exactly one event.
- States and transitions:
  - IDLE: on press event, latch i_guess into o_cmp_guess, clear o_cmp_err, go to ISSUE.
  - ISSUE: o_cmp_start = 1 for exactly this cycle, then go to WAIT_CMP.
  - WAIT_CMP: i_cmp_done is sampled only in this state.
    - done with result 00/01/10: go to UPDATE.
    - done with result 11: set o_cmp_err, go to IDLE; no attempt consumed, flags unchanged.
    - No done within CMP_TIMEOUT cycles of entering the state: set o_cmp_err, go to IDLE; no attempt consumed.
  - UPDATE (one cycle):
    - Load flags one-hot from the result.
    - Pulse o_update_leds.
    - Decrement attempts, saturating at 0.
    - Next state: WON if equal (takes precedence, including on the last attempt); else LOST if attempts reach 0; else IDLE.
  - WON / LOST: terminal until reset. Flags and attempts hold, o_game_over = 1, presses ignored.
- Latency (press event in cycle T):
  - o_cmp_start high in cycle T+1.
  - With i_cmp_done in cycle D, the new flags, o_update_leds and the decremented count are all visible in cycle D+2.
- o_cmp_guess stays stable from ISSUE until the next accepted press.
- i_cmp_done in the same cycle as o_cmp_start is ignored; the earliest valid done is cycle T+2.

Test Plan (sim with DEBOUNCE_CYCLES=4, CMP_TIMEOUT=15, MAX_ATTEMPTS=7):
- Reset then idle -> attempts=7, all flags 0, o_cmp_start never asserted; a 3-cycle enter glitch -> no o_cmp_start.
- Guess 0x2A, hold enter 20 cycles, comparator returns 00 two cycles after start -> exactly one o_cmp_start, o_cmp_guess=0x2A, o_under=1, one o_update_leds pulse, attempts=6.
- Result 10 on the 3rd press -> o_equal=1, attempts=4, o_game_over=1; further presses give no o_cmp_start.
- Seven consecutive 01 results -> attempts 6..0, o_over=1, LOST, o_game_over=1; an 8th press is ignored.
- No i_cmp_done for 15 cycles, then a case returning 11 -> o_cmp_err=1 and attempts unchanged in both; the next accepted press clears o_cmp_err.
- reset=0 during WAIT_CMP, then i_cmp_done after release -> attempts=7, flags 0, no o_update_leds pulse.
